regfile_mp: RTL and testbench

//  Parametrised multi-read-port integer register file for the RV32 core datapath, between decode and execute.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_init_seq.sv | 66 ++++++
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, constants and helpers for the regfile_mp register file.
package regfile_pkg;

  // Sequencer states: INIT sweeps zeros into every entry, RUN is normal operation.
  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  // Address of the hardwired zero entry (x0).
  localparam int RF_ZERO_ADDR = 0;

  // Address width for a given number of entries (at least one bit).
  function automatic int rf_addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: power-up clear sequencer for regfile_mp.
// After reset it walks clr_idx from 0 to DEPTH-1, requesting one zero write per
// cycle, then enters RUN for good. busy is high for exactly DEPTH cycles after
// reset is released. Reset (rst, active low) restarts the sweep from any state.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = rf_addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          run,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  rf_state_t       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;

  // State and sweep-index registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RF_INIT;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state logic and sequencer outputs.
  // NOTE: every output and next-state variable gets a default at the top of the
  // block, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    run       = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      RF_INIT: begin
        clr_we    = 1'b1;
        busy      = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        run = 1'b1;
      end
      default: begin
        state_d = RF_INIT;
      end
    endcase
  end

  assign clr_addr = clr_idx_q;

endmodule : regfile_init_seq

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with power-up clear,
// hardwired zero entry and a pending-write scoreboard for hazard detection.
// One synchronous write port (writeback), NUM_RD combinational read ports.
// Optional feature macro: REGFILE_BYPASS_EN enables write-first forwarding from
// the write port to matching read ports in the same cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int DEPTH  = 32,
  parameter  int NUM_RD = 2,
  localparam int AW     = rf_addr_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [XLEN-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]   raddr,
  output logic [NUM_RD*XLEN-1:0] rdata,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_addr,
  output logic [NUM_RD-1:0]      pend,
  output logic                   busy
);

  localparam logic [AW-1:0] ZERO_A = AW'(RF_ZERO_ADDR);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            run;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  logic [DEPTH-1:0] sb_q, sb_d;
  logic             wr_run;
  logic             set_run;

  regfile_init_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .run      (run),
    .busy     (busy)
  );

  // Architectural write and scoreboard-set qualifiers; x0 is never a target.
  assign wr_run  = run && we && (waddr != ZERO_A);
  assign set_run = run && sb_set && (sb_addr != ZERO_A);

  // Single array write port: the clear sweep in INIT, writeback in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (wr_run) begin
      mem_we = 1'b1;
    end
  end

  // Register array storage.
  // NOTE: the array has no reset term; clearing it is the sweep's job, which
  // keeps it mappable to plain RAM/latch-array cells without a reset tree.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Scoreboard update: writeback clears, issue sets; set wins on the same entry.
  always_comb begin
    sb_d = sb_q;
    if (wr_run) begin
      sb_d[waddr] = 1'b0;
    end
    if (set_run) begin
      sb_d[sb_addr] = 1'b1;
    end
    sb_d[RF_ZERO_ADDR] = 1'b0;
  end

  // Scoreboard register; reset clears every pending bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Read ports: combinational lookup, x0 and INIT read as zero.
  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            pd;
    rdata = '0;
    pend  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = raddr[i*AW +: AW];
      rd = '0;
      pd = 1'b0;
      if (run && (ra != ZERO_A)) begin
        rd = mem_q[ra];
        pd = sb_q[ra];
`ifdef REGFILE_BYPASS_EN
        // Write-first forwarding: the in-flight write is visible and no longer pending,
        // unless a new producer is being issued to the same entry this cycle.
        if (wr_run && (ra == waddr)) begin
          rd = wdata;
          pd = sb_set && (sb_addr == ra);
        end
`endif
      end
      rdata[i*XLEN +: XLEN] = rd;
      pend[i]               = pd;
    end
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (default parameters).
// A behavioural model (plain arrays plus a remaining-sweep-cycles counter)
// predicts rdata, pend and busy every cycle; directed scenarios add explicit checks.
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   we = 1'b0;
  logic [AW-1:0]          waddr = '0;
  logic [XLEN-1:0]        wdata = '0;
  logic [NUM_RD*AW-1:0]   raddr = '0;
  logic [NUM_RD*XLEN-1:0] rdata;
  logic                   sb_set = 1'b0;
  logic [AW-1:0]          sb_addr = '0;
  logic [NUM_RD-1:0]      pend;
  logic                   busy;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata   (rdata),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .pend    (pend),
    .busy    (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: register contents, pending bits, sweep cycles still to go.
  logic [XLEN-1:0] m_mem [DEPTH];
  bit              m_sb  [DEPTH];
  int              m_left;

  function automatic void model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k] = '0;
      m_sb[k]  = 1'b0;
    end
    m_left = DEPTH;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] ra);
    if (m_left > 0 || ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr != 0 && ra == waddr) return wdata;
`endif
    return m_mem[ra];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] ra);
    if (m_left > 0 || ra == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr != 0 && ra == waddr) return sb_set && (sb_addr == ra);
`endif
    return m_sb[ra];
  endfunction

  // Values observed just before the most recent active edge.
  logic [XLEN-1:0] o_rd [NUM_RD];
  logic            o_pend [NUM_RD];
  logic            o_busy;

  // One clock cycle: drive at negedge, check outputs, then apply the edge to the model.
  task automatic cyc(input logic i_we, input logic [AW-1:0] i_wa, input logic [XLEN-1:0] i_wd,
                     input logic [AW-1:0] i_r0, input logic [AW-1:0] i_r1,
                     input logic i_ss, input logic [AW-1:0] i_sa);
    logic [AW-1:0] ra;
    @(negedge clk);
    we      = i_we;
    waddr   = i_wa;
    wdata   = i_wd;
    raddr   = {i_r1, i_r0};
    sb_set  = i_ss;
    sb_addr = i_sa;
    #1;
    o_busy = busy;
    check("busy", busy, m_left > 0);
    for (int p = 0; p < NUM_RD; p++) begin
      ra        = raddr[p*AW +: AW];
      o_rd[p]   = rdata[p*XLEN +: XLEN];
      o_pend[p] = pend[p];
      check($sformatf("rd%0d[%0d]", p, ra), o_rd[p], exp_rd(ra));
      check($sformatf("pend%0d[%0d]", p, ra), o_pend[p], exp_pend(ra));
    end
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
    end else begin
      if (we && waddr != 0) begin
        m_mem[waddr] = wdata;
        m_sb[waddr]  = 1'b0;
      end
      if (sb_set && sb_addr != 0) m_sb[sb_addr] = 1'b1;
    end
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    cyc(1'b0, '0, '0, r0, r1, 1'b0, '0);
  endtask

  // Assert reset away from the edge, check the reset outputs, release after a posedge.
  task automatic apply_reset();
    @(negedge clk);
    rst    = 1'b0;
    we     = 1'b0;
    sb_set = 1'b0;
    raddr  = {AW'($urandom_range(1, DEPTH - 1)), AW'($urandom_range(1, DEPTH - 1))};
    #1;
    check("rst_busy", busy, 1'b1);
    check("rst_rdata", rdata, '0);
    check("rst_pend", pend, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Count busy cycles after a reset release, with optional random writes/sets during INIT.
  task automatic count_busy(input string tag, input bit noisy);
    int cnt;
    cnt = 0;
    for (int k = 0; k < DEPTH + 8; k++) begin
      cyc(noisy ? 1'b1 : 1'b0, AW'($urandom), $urandom,
          AW'($urandom), AW'($urandom), noisy ? 1'b1 : 1'b0, AW'($urandom));
      if (o_busy) cnt++;
      else break;
    end
    check(tag, cnt, DEPTH);
  endtask

  logic [AW-1:0] init_addrs [$];

  initial begin
    #100_000_0;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();

    // 1: power-up sweep length, everything reads zero afterwards.
    apply_reset();
    count_busy("t1_busy_cycles", 1'b0);
    for (int a = 0; a < DEPTH; a += 2) begin
      idle(AW'(a), AW'(a + 1));
      check("t1_zero0", o_rd[0], '0);
      check("t1_zero1", o_rd[1], '0);
    end

    // 2: write then read on both ports.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, '0, '0, 1'b0, '0);
    idle(5'd5, 5'd5);
    check("t2_rd0", o_rd[0], 32'hDEADBEEF);
    check("t2_rd1", o_rd[1], 32'hDEADBEEF);

    // 3: x0 ignores writes and scoreboard sets.
    cyc(1'b1, 5'd0, 32'h12345678, '0, '0, 1'b1, 5'd0);
    idle(5'd0, 5'd0);
    check("t3_rd0", o_rd[0], '0);
    check("t3_pend0", o_pend[0], 1'b0);

    // 4: scoreboard set, clear by writeback, set-wins collision.
    cyc(1'b0, '0, '0, 5'd9, 5'd9, 1'b1, 5'd9);
    idle(5'd9, 5'd0);
    check("t4_set", o_pend[0], 1'b1);
    cyc(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd0, 1'b0, '0);
    idle(5'd9, 5'd0);
    check("t4_clr", o_pend[0], 1'b0);
    check("t4_data", o_rd[0], 32'hCAFEF00D);
    cyc(1'b0, '0, '0, 5'd9, 5'd0, 1'b1, 5'd9);
    cyc(1'b1, 5'd9, 32'h0BADBEEF, 5'd9, 5'd0, 1'b1, 5'd9);
    idle(5'd9, 5'd0);
    check("t4_both", o_pend[0], 1'b1);

    // 5: read-during-write on the same address.
    cyc(1'b1, 5'd3, 32'h11111111, '0, '0, 1'b0, '0);
    cyc(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd0, 1'b0, '0);
`ifdef REGFILE_BYPASS_EN
    check("t5_same_cycle", o_rd[0], 32'hA5A5A5A5);
`else
    check("t5_same_cycle", o_rd[0], 32'h11111111);
`endif
    idle(5'd3, 5'd0);
    check("t5_after", o_rd[0], 32'hA5A5A5A5);

    // 6: reset at cycle 10 of the sweep restarts it; writes during INIT are dropped.
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      init_addrs.push_back(AW'(k + 1));
      cyc(1'b1, AW'(k + 1), 32'hF0000000 | k, '0, '0, 1'b1, AW'(k + 1));
    end
    apply_reset();
    count_busy("t6_busy_cycles", 1'b1);
    foreach (init_addrs[j]) begin
      idle(init_addrs[j], init_addrs[j]);
      check("t6_dropped", o_rd[0], '0);
      check("t6_nopend", o_pend[1], 1'b0);
    end

    // Randomised traffic, addresses biased to collide, one reset mid-run.
    for (int n = 0; n < 1500; n++) begin
      logic [AW-1:0] wa, r0, r1, sa;
      wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      r0 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      sa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      if (n == 700) apply_reset();
      cyc(1'($urandom_range(0, 1)), wa, $urandom, r0, r1, 1'($urandom_range(0, 2) == 0), sa);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_regfile_mp
